// File: rtl/ysyx_22041211_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave SRAM arbiter, one transaction in flight.
// Define YSYX_22041211_ARB_RR_EN for round-robin ties; default is LSU priority.
module ysyx_22041211_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ifu_req_valid,
   output logic                      ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     ifu_addr,
   output logic                      ifu_rsp_valid,
   input  logic                      ifu_rsp_ready,
   output logic [DATA_WIDTH-1:0]     ifu_rdata,
   input  logic                      lsu_req_valid,
   output logic                      lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]     lsu_addr,
   input  logic                      lsu_wen,
   input  logic [DATA_WIDTH-1:0]     lsu_wdata,
   input  logic [DATA_WIDTH/8-1:0]   lsu_wmask,
   output logic                      lsu_rsp_valid,
   input  logic                      lsu_rsp_ready,
   output logic [DATA_WIDTH-1:0]     lsu_rdata,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic                      mem_wen,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wmask,
   input  logic                      mem_rsp_valid,
   output logic                      mem_rsp_ready,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RSP  = 2'b10
   } state_t;

   state_t state, state_nxt;
   logic   owner, owner_nxt;
   logic   own_req_valid;
   logic   own_rsp_ready;
   logic   grant;

   assign own_req_valid = owner ? lsu_req_valid : ifu_req_valid;
   assign own_rsp_ready = owner ? lsu_rsp_ready : ifu_rsp_ready;

`ifdef YSYX_22041211_ARB_RR_EN
   logic last_owner;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_owner <= 1'b0;
      else if (state == RSP && mem_rsp_valid && own_rsp_ready)
         last_owner <= owner;
   end

   // on a tie the master that was not served last wins
   assign grant = (ifu_req_valid && lsu_req_valid) ? ~last_owner
                                                   : lsu_req_valid;
`else
   assign grant = lsu_req_valid;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      unique case (state)
         IDLE: begin
            if (ifu_req_valid || lsu_req_valid) begin
               state_nxt = REQ;
               owner_nxt = grant;
            end
         end
         REQ: begin
            // an abandoned request drops back without touching the slave
            if (!own_req_valid)
               state_nxt = IDLE;
            else if (mem_req_ready)
               state_nxt = RSP;
         end
         RSP: begin
            if (mem_rsp_valid && own_rsp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      ifu_rdata     = '0;
      lsu_rdata     = '0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_wen       = 1'b0;
      mem_wdata     = '0;
      mem_wmask     = '0;
      mem_rsp_ready = 1'b0;
      busy          = (state != IDLE);
      unique case (state)
         REQ: begin
            mem_req_valid = own_req_valid;
            if (owner) begin
               mem_addr      = lsu_addr;
               mem_wen       = lsu_wen;
               mem_wdata     = lsu_wdata;
               mem_wmask     = lsu_wmask;
               lsu_req_ready = mem_req_ready;
            end else begin
               mem_addr      = ifu_addr;
               ifu_req_ready = mem_req_ready;
            end
         end
         RSP: begin
            mem_rsp_ready = own_rsp_ready;
            if (owner) begin
               lsu_rsp_valid = mem_rsp_valid;
               lsu_rdata     = mem_rdata;
            end else begin
               ifu_rsp_valid = mem_rsp_valid;
               ifu_rdata     = mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule
